// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types, sizes and key-byte helper
package rc4_pkg;

    localparam int S_SIZE         = 256;
    localparam int KEY_LENGTH_DEF = 3;
    localparam int KEY_MAX        = 32;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        CP_I,
        RD_J,
        WT_J,
        CP_J,
        WR_I,
        WR_J,
        NX,
        DONE
    } ksa_state_t;

    // Byte 0 is the most significant byte of the key_len-byte key.
    function automatic logic [7:0] key_byte(
        input logic [8*KEY_MAX-1:0] key,
        input int unsigned          key_len,
        input int unsigned          idx
    );
        return key[8*(key_len-1-idx) +: 8];
    endfunction

endpackage

// File: rtl/ksa_shuffler.sv
// rtl/ksa_shuffler.sv - RC4 key-scheduling swap pass over a single-port S RAM
module ksa_shuffler
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH = KEY_LENGTH_DEF,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    output logic [ADDR_W-1:0]       address,
    output logic [DATA_W-1:0]       ram_in,
    output logic                    write_enable,
    input  logic [DATA_W-1:0]       q,
    output logic                    busy,
    output logic                    finished
);

    localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(S_SIZE - 1);

    ksa_state_t          r_state;
    ksa_state_t          w_state_next;
    logic [ADDR_W-1:0]   r_i;
    logic [ADDR_W-1:0]   r_j;
    logic [KW-1:0]       r_k;
    logic [DATA_W-1:0]   r_si;
    logic [DATA_W-1:0]   r_sj;
    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_ram_in;
    logic                r_write_enable;
    logic [8*KEY_MAX-1:0] w_key_ext;
    logic [7:0]          w_key_byte;
    logic [ADDR_W-1:0]   w_j_next;

    assign w_key_ext  = (8*KEY_MAX)'(secret_key);
    assign w_key_byte = key_byte(w_key_ext, KEY_LENGTH, int'(r_k));
    // Address-width wrap drops the carry, giving j mod 256.
    assign w_j_next   = r_j + ADDR_W'(q) + ADDR_W'(w_key_byte);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        finished     = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_state_next = RD_I;
            end
            RD_I: w_state_next = WT_I;
            WT_I: w_state_next = CP_I;
            CP_I: w_state_next = RD_J;
            RD_J: w_state_next = WT_J;
            WT_J: w_state_next = CP_J;
            CP_J: w_state_next = WR_I;
            WR_I: w_state_next = WR_J;
            WR_J: w_state_next = NX;
            NX:   w_state_next = (r_i == LAST_I) ? DONE : RD_I;
            DONE: begin
                busy     = 1'b0;
                finished = 1'b1;
                if (!start) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_i            <= '0;
            r_j            <= '0;
            r_k            <= '0;
            r_si           <= '0;
            r_sj           <= '0;
            r_address      <= '0;
            r_ram_in       <= '0;
            r_write_enable <= 1'b0;
        end else begin
            r_write_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                RD_I: r_address <= r_i;
                CP_I: begin
                    r_si <= q;
                    r_j  <= w_j_next;
                end
                RD_J: r_address <= r_j;
                CP_J: r_sj <= q;
                WR_I: begin
                    r_address      <= r_i;
                    r_ram_in       <= r_sj;
                    r_write_enable <= 1'b1;
                end
                WR_J: begin
                    r_address      <= r_j;
                    r_ram_in       <= r_si;
                    r_write_enable <= 1'b1;
                end
                NX: begin
                    if (r_i != LAST_I) begin
                        r_i <= r_i + 1'b1;
                        r_k <= (r_k == KW'(KEY_LENGTH - 1)) ? '0 : r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign address      = r_address;
    assign ram_in       = r_ram_in;
    assign write_enable = r_write_enable;

endmodule

// File: tb/tb_ksa_shuffler.sv
// tb/tb_ksa_shuffler.sv - bench for ksa_shuffler against a software RC4 KSA
module tb_ksa_shuffler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  address;
    logic [7:0]  ram_in;
    logic        write_enable;
    logic [7:0]  q;
    logic        busy;
    logic        finished;

    logic [7:0]  mem [256];
    logic [7:0]  gold [256];
    logic        ram_init = 1'b0;
    logic [15:0] wr_log [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ksa_shuffler #(.KEY_LENGTH(3), .ADDR_W(8), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .secret_key  (secret_key),
        .address     (address),
        .ram_in      (ram_in),
        .write_enable(write_enable),
        .q           (q),
        .busy        (busy),
        .finished    (finished)
    );

    always @(posedge clk) begin
        if (ram_init) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (write_enable) begin
            mem[address] <= ram_in;
            wr_log.push_back({address, ram_in});
        end
        q <= mem[address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic golden(input logic [23:0] key);
        int         j;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int n = 0; n < 256; n++) gold[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + int'(gold[n]) + int'(kb[n % 3])) % 256;
            t = gold[n];
            gold[n] = gold[j];
            gold[j] = t;
        end
    endtask

    task automatic check_array(input string tag, input logic [23:0] key);
        int bad;
        int first;
        golden(key);
        bad   = 0;
        first = -1;
        for (int n = 0; n < 256; n++) begin
            if (mem[n] !== gold[n]) begin
                bad++;
                if (first < 0) first = n;
            end
        end
        if (first >= 0)
            $display("note %s: first differing entry %0d dut=%0h gold=%0h", tag, first, mem[first], gold[first]);
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic init_ram();
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
    endtask

    // Pulses start for one cycle, then waits for finished; cyc counts edges from the sampling edge.
    task automatic run_pass(input logic [23:0] key, output int cyc, output int wbase);
        init_ram();
        secret_key = key;
        start      = 1'b1;
        wbase      = wr_log.size();
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int          cyc;
        int          wbase;
        int          fin_drop;
        int          seen_fin;
        logic [23:0] key;

        reset      = 1'b1;
        start      = 1'b0;
        secret_key = 24'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_finished", 32'(finished), 32'd0);
        chk("reset_we", 32'(write_enable), 32'd0);
        chk("reset_address", 32'(address), 32'd0);
        chk("reset_ram_in", 32'(ram_in), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // all-zero key: early swaps and latency
        run_pass(24'h000000, cyc, wbase);
        chk("zero_latency", 32'(cyc), 32'd2305);
        chk("zero_finished", 32'(finished), 32'd1);
        chk("zero_wr_count", 32'(wr_log.size() - wbase), 32'd512);
        chk("zero_i0_wr_a", 32'(wr_log[wbase+0]), 32'h0000);
        chk("zero_i0_wr_b", 32'(wr_log[wbase+1]), 32'h0000);
        chk("zero_i2_wr_a", 32'(wr_log[wbase+4]), 32'h0203);
        chk("zero_i2_wr_b", 32'(wr_log[wbase+5]), 32'h0302);
        check_array("zero_array", 24'h000000);
        @(negedge clk);
        chk("zero_idle_finished", 32'(finished), 32'd0);
        chk("zero_idle_busy", 32'(busy), 32'd0);

        run_pass(24'h00033C, cyc, wbase);
        chk("k33c_i1_wr_a", 32'(wr_log[wbase+2]), 32'h0104);
        chk("k33c_i1_wr_b", 32'(wr_log[wbase+3]), 32'h0401);
        chk("k33c_wr_count", 32'(wr_log.size() - wbase), 32'd512);
        check_array("k33c_array", 24'h00033C);
        @(negedge clk);

        run_pass(24'hFFFFFF, cyc, wbase);
        chk("kfff_latency", 32'(cyc), 32'd2305);
        chk("kfff_wr_count", 32'(wr_log.size() - wbase), 32'd512);
        check_array("kfff_array", 24'hFFFFFF);
        @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            key = 24'($urandom);
            run_pass(key, cyc, wbase);
            chk("rand_latency", 32'(cyc), 32'd2305);
            check_array("rand_array", key);
            @(negedge clk);
        end

        // start held high across the whole pass and beyond
        init_ram();
        key        = 24'($urandom);
        secret_key = key;
        start      = 1'b1;
        wbase      = wr_log.size();
        fin_drop   = 0;
        seen_fin   = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (finished) seen_fin = 1;
            else if (seen_fin != 0) fin_drop++;
        end
        chk("held_wr_count", 32'(wr_log.size() - wbase), 32'd512);
        chk("held_fin_drop", 32'(fin_drop), 32'd0);
        chk("held_finished", 32'(finished), 32'd1);
        chk("held_busy", 32'(busy), 32'd0);
        check_array("held_array", key);
        start = 1'b0;
        @(negedge clk);
        chk("held_release_finished", 32'(finished), 32'd0);
        chk("held_release_busy", 32'(busy), 32'd0);
        init_ram();
        key        = 24'($urandom);
        secret_key = key;
        start      = 1'b1;
        @(negedge clk);
        chk("restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        cyc   = 1;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("restart_latency", 32'(cyc), 32'd2305);
        check_array("restart_array", key);
        @(negedge clk);

        // reset in the middle of a pass, then a clean rerun
        init_ram();
        key        = 24'($urandom);
        secret_key = key;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_we", 32'(write_enable), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_finished", 32'(finished), 32'd0);
        chk("midreset_address", 32'(address), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_pass(key, cyc, wbase);
        chk("midreset_latency", 32'(cyc), 32'd2305);
        chk("midreset_wr_count", 32'(wr_log.size() - wbase), 32'd512);
        check_array("midreset_array", key);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
